alu_issue_seq: RTL and testbench

//  Operand-issue and writeback sequencer for the alutoResult datapath (alu + registered result).
//  - Accepts ALU instructions on a valid/ready handshake.
//  - Reads operands from an internal register file and drives A/B/ALUOp.
//  - Captures Zero, then writes the registered Result back to the destination register.
//  - Sits between the instruction source and alutoResult, closing the loop at both ends of its interface.

---
 rtl/alu_issue_pkg.sv | 18 +
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_seq.sv | 120 ++++++++++++
 tb/tb_alu_issue_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue_seq operand-issue/writeback sequencer.
package alu_issue_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WB
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for alu_issue_seq: two combinational operand reads, one debug read,
// one synchronous write, async active-low clear, entry 0 hardwired to zero.
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
    rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
    dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Operand-issue and writeback sequencer in front of alutoResult (1 instruction per 3 cycles).
// Optional ALU_ISSUE_PERF_EN adds perf_cnt, a wrapping count of done pulses.
module alu_issue_seq
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [2:0]    alu_ALUOp,
  input  logic          alu_Zero,
  input  logic [DW-1:0] alu_Result,
  output logic          done,
  output logic [AW-1:0] done_rd,
  output logic [DW-1:0] done_data,
  output logic          done_zero,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]   perf_cnt
`endif
);

  state_e        state;
  logic [AW-1:0] rd_q;
  logic          zero_q;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;

  alu_regfile #(
    .NREGS (NREGS),
    .AW    (AW),
    .DW    (DW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (in_rs),
    .ra_data  (ra_data),
    .rb_addr  (in_rt),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (state == WB),
    .waddr    (rd_q),
    .wdata    (alu_Result)
  );

  // Operands are resolved from the register file at the accept edge and held in the
  // alu_A/alu_B/alu_ALUOp registers, so they are stable for the whole ISSUE cycle;
  // only rd needs a separate latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      rd_q      <= '0;
      zero_q    <= 1'b0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_ALUOp <= '0;
      done      <= 1'b0;
      done_rd   <= '0;
      done_data <= '0;
      done_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_A     <= ra_data;
            alu_B     <= in_use_imm ? in_imm : rb_data;
            alu_ALUOp <= in_op;
            rd_q      <= in_rd;
            in_ready  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          zero_q <= alu_Zero;
          state  <= WB;
        end
        WB: begin
          done      <= 1'b1;
          done_rd   <= rd_q;
          done_data <= alu_Result;
          done_zero <= zero_q;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (state == WB) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq with an alutoResult stand-in; set ALU_ISSUE_PERF_EN for perf_cnt.
module tb_alu_issue_seq;
  import alu_issue_pkg::*;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [AW-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic          in_use_imm = 1'b0;
  logic [DW-1:0] in_imm = '0;
  logic [DW-1:0] alu_A, alu_B;
  logic [2:0]    alu_ALUOp;
  logic          alu_Zero;
  logic [DW-1:0] alu_Result;
  logic          done;
  logic [AW-1:0] done_rd;
  logic [DW-1:0] done_data;
  logic          done_zero;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]   perf_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned dones_since_reset = 0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          zero;
    int unsigned   cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] rf_m [8];

  alu_issue_seq #(.NREGS(8), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_ALUOp  (alu_ALUOp),
    .alu_Zero   (alu_Zero),
    .alu_Result (alu_Result),
    .done       (done),
    .done_rd    (done_rd),
    .done_data  (done_data),
    .done_zero  (done_zero),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_cnt   (perf_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // alutoResult stand-in: combinational Zero, Result registered one cycle later.
  logic [31:0] alu_now;
  assign alu_now  = alu_ref(alu_ALUOp, alu_A, alu_B);
  assign alu_Zero = (alu_now == 32'd0);
  always @(posedge clk or negedge rst) begin
    if (!rst) alu_Result <= '0;
    else      alu_Result <= alu_now;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_rd=%0d data=0x%08h expected no done", done_rd, done_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check32("done_rd",    32'(done_rd),   32'(e.rd));
        check32("done_data",  done_data,      e.data);
        check32("done_zero",  32'(done_zero), 32'(e.zero));
        check32("done_cycle", cyc,            e.cyc);
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    sbq.delete();
    dones_since_reset = 0;
  endfunction

  // Called at a negedge; returns with in_valid still high, one negedge past the accept edge.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] rd, input logic use_imm, input logic [31:0] imm,
                      output int unsigned acc);
    logic [31:0] a, b, r;
    int unsigned waited;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_use_imm = use_imm; in_imm = imm;
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1 within 20 cycles", in_ready);
      acc = 0;
      return;
    end
    a = rf_m[rs];
    b = use_imm ? imm : rf_m[rt];
    r = alu_ref(op, a, b);
    sbq.push_back('{rd: rd, data: r, zero: (r == 32'd0), cyc: cyc + 3});
    if (rd != 0) rf_m[rd] = r;
    dones_since_reset++;
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    check32("sb_drain", sbq.size(), 32'd0);
  endtask

  task automatic check_reg(input string name, input logic [AW-1:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check32(name, dbg_data, exp);
  endtask

  initial begin
    int unsigned acc, prev_acc;
    logic [31:0] imm;

    // Reset held with an instruction presented
    model_reset();
    in_valid = 1'b1; in_op = OP_ADD; in_rd = 3'd6; in_use_imm = 1'b1; in_imm = 32'd99;
    repeat (3) @(negedge clk);
    check32("rst_in_ready",  32'(in_ready),  32'd1);
    check32("rst_done",      32'(done),      32'd0);
    check32("rst_done_data", done_data,      32'd0);
    check32("rst_alu_A",     alu_A,          32'd0);
    check32("rst_alu_op",    32'(alu_ALUOp), 32'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_dbg", AW'(i), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("no_accept_in_reset", 32'(in_ready), 32'd1);

    // Directed dependent chain
    send(OP_ADD, 3'd0, 3'd0, 3'd1, 1'b1, 32'd5, acc);
    in_valid = 1'b0;
    send(OP_ADD, 3'd1, 3'd0, 3'd2, 1'b1, 32'd7, acc);
    in_valid = 1'b0;
    drain();
    check_reg("r1", 3'd1, 32'd5);
    check_reg("r2", 3'd2, 32'd12);

    send(OP_SUB, 3'd2, 3'd2, 3'd3, 1'b0, 32'd0, acc);
    send(OP_SUB, 3'd1, 3'd2, 3'd4, 1'b0, 32'd0, acc);
    in_valid = 1'b0;
    drain();
    check_reg("r4", 3'd4, 32'hFFFF_FFF9);

    send(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'd1, acc);
    in_valid = 1'b0;
    drain();
    check_reg("r0_stays_zero", 3'd0, 32'd0);

    // Reset during ISSUE abandons the instruction
    in_op = OP_OR; in_rs = 3'd2; in_rt = 3'd1; in_rd = 3'd5; in_use_imm = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check32("midrst_done",  32'(done),     32'd0);
    check32("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check32("post_rst_ready", 32'(in_ready), 32'd1);
    check_reg("r5_cleared", 3'd5, 32'd0);

    // Back-to-back burst with in_valid held high
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      send(3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(1, 7)), 1'b1, 32'($urandom_range(0, 1000)), acc);
      if (i > 0) check32("burst_spacing", acc - prev_acc, 32'd3);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    drain();
`ifdef ALU_ISSUE_PERF_EN
    check32("perf_cnt", perf_cnt, 32'(dones_since_reset));
`endif

    // Randomized traffic with idle gaps and corner immediates
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       imm = 32'h0000_0000;
        1:       imm = 32'hFFFF_FFFF;
        2:       imm = 32'h8000_0000;
        default: imm = $urandom;
      endcase
      send(3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm, acc);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    drain();
    for (int i = 0; i < 8; i++) check_reg("final_rf", AW'(i), rf_m[i]);
`ifdef ALU_ISSUE_PERF_EN
    check32("perf_cnt_final", perf_cnt, 32'(dones_since_reset));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
